crossbar3_alloc: RTL and testbench
==================================

Name: crossbar3_alloc

Overview:
- Allocation and flow-control engine that drives the 3x3 data/ctrl crossbar select and domain lines.
- Accepts per-input requests, each carrying a destination output, a last-beat flag and a 1-bit security domain.
- Runs an independent round-robin arbiter per output and holds each grant for a whole multi-beat packet.
- Produces crossbar selects, per-output valid and domain, and per-input ready. It is the control end of the crossbar datapath.

Parameters:
- p_num_ports, 3, number of inputs and outputs (fixed at 3; select width 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clk rising edge).
- in0_val, in1_val, in2_val  input  1 each  request valid per input.
- in0_dest, in1_dest, in2_dest  input  2 each  destination output 0..2; 3 = no request.
- in0_last, in1_last, in2_last  input  1 each  current beat ends the packet.
- in0_domain, in1_domain, in2_domain  input  1 each  security domain of the input's data.
- in0_rdy, in1_rdy, in2_rdy  output  1 each  beat accepted this cycle.
- out0_rdy, out1_rdy, out2_rdy  input  1 each  downstream ready per output.
- out0_val, out1_val, out2_val  output  1 each  beat present on the output.
- sel0, sel1, sel2  output  2 each  crossbar select per output; 0..2 = input index, 3 = idle.
- out0_domain, out1_domain, out2_domain  output  1 each  domain of the granted input.

Behaviour:
- Reset (reset==0 at clk edge): every output FSM goes to IDLE, sel*=3, out*_val=0, out*_domain=0, rr_ptr*=0, all in*_rdy=0. Reset applied mid-packet abandons the packet with no completion beat.
- Each output k has an FSM with two states: IDLE and LOCKED(g), where g is the granted input.
- IDLE arbitration:
  - Requesters for k are inputs i with in_i_val=1 and in_i_dest==k.
  - Priority scan order is rr_ptr_k, rr_ptr_k+1, rr_ptr_k+2, all mod 3; the first requester found wins.
  - If a winner exists: next state LOCKED(g), sel_k<=g, out_k_domain<=in_g_domain, registered at the edge.
  - If no requesters: stay IDLE, sel_k stays 3.
  - Arbitration latency is 1 cycle; no beat transfers in the cycle the grant is decided.
- LOCKED(g):
  - out_k_val = in_g_val & (in_g_dest==k).
  - in_g_rdy = out_k_rdy & (in_g_dest==k).
  - A transfer happens when in_g_val & in_g_rdy.
  - A transfer with in_g_last=1 gives next state IDLE, sel_k<=3, rr_ptr_k<=(g+1) mod 3.
  - Any other transfer, or no transfer, stays LOCKED.
- out_k_domain is latched at grant and held constant for the whole lock, even if in_g_domain toggles mid-packet. The label can never change within a packet.
- An input that is not granted anywhere has in_rdy=0.
- One input targets exactly one output per cycle, so no input is granted by two outputs in the same cycle. If an input changes dest while locked, the old output stalls (val=0) until the input returns.
- dest==3 is never a request and never receives ready.
- Simultaneous events:
  - A last-beat release and a new request on the same output: release takes precedence that cycle; the new arbitration happens on the next cycle, in IDLE.
  - The three outputs arbitrate independently in the same cycle.
- Single-beat packet (last=1 on first beat): minimum 2 cycles per packet per output; back-to-back packets to the same output sustain 1 beat per 2 cycles.
- sel_k, out_k_domain and the FSM state are registered; val/rdy are combinational from the registered state plus live inputs. There is no combinational path from out_rdy to in_val.

Decomposition:
- Shared package holds the select encoding constants (SEL_IN0=0, SEL_IN1=1, SEL_IN2=2, SEL_IDLE=3) and the FSM state encoding (IDLE=0, LOCKED=1).
- One sub-module, crossbar3_alloc_out: the per-output FSM, rr pointer and domain latch. It is instantiated three times with its output index as a parameter. The top level ORs per-output readies into in*_rdy.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all in*_val=1 → sel*=3, out*_val=0, in*_rdy=0; release, and next cycle sel0 = 0 when all inputs target 0.
- Contention and round-robin: inputs 0,1,2 all send 1-beat packets to output 1, out1_rdy=1 → grants in order 0,1,2,0; each grant yields exactly one in_rdy pulse, and sel1 alternates with 3.
- Multi-beat lock: input 2 sends a 4-beat packet to output 0 while input 0 also requests output 0 → sel0 stays 2 for all 4 beats, in0_rdy stays 0; after last, sel0=3 for one cycle, then sel0=0.
- Backpressure: a locked packet with out2_rdy toggled 1,0,0,1 → in_rdy mirrors out2_rdy, with no beat lost or duplicated; the last beat only releases when out2_rdy=1.
- Domain hold: granted input domain=1 at grant, toggled to 0 mid-packet → out_domain stays 1 until release; the next grant shows the new domain.
- Parallel and mid-reset: inputs 0→2, 1→0, 2→1 simultaneously → all three lock in the same cycle; asserting reset mid-packet → all sel return to 3 the next cycle.

Source files
------------

// File: rtl/crossbar3_alloc_pkg.sv
// Shared encodings for the 3x3 crossbar allocator.
// Select codes, output FSM states and a mod-3 increment helper.
package crossbar3_alloc_pkg;

  localparam int P_NUM_PORTS = 3;

  localparam logic [1:0] SEL_IN0  = 2'd0;
  localparam logic [1:0] SEL_IN1  = 2'd1;
  localparam logic [1:0] SEL_IN2  = 2'd2;
  localparam logic [1:0] SEL_IDLE = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic [1:0] inc3(
    input logic [1:0] x
  );
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

endpackage

// File: rtl/crossbar3_alloc_out.sv
// Per-output allocator: round-robin grant, packet lock, domain latch.
// Ports: packed per-input requests in, sel/val/domain/per-input ready out.
module crossbar3_alloc_out
  import crossbar3_alloc_pkg::*;
#(
  parameter logic [1:0] K = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in_val,
  input  logic [5:0] in_dest,
  input  logic [2:0] in_last,
  input  logic [2:0] in_domain,
  input  logic       out_rdy,
  output logic       out_val,
  output logic [1:0] sel,
  output logic       out_domain,
  output logic [2:0] grant_rdy
);

  state_e     state, state_nx;
  logic [1:0] sel_nx;
  logic [1:0] rr, rr_nx;
  logic       dom_nx;
  logic [1:0] cand;
  logic       found;
  logic [1:0] dst [3];
  logic [2:0] req;

  assign dst[0] = in_dest[1:0];
  assign dst[1] = in_dest[3:2];
  assign dst[2] = in_dest[5:4];

  always_comb begin
    for (int i = 0; i < 3; i++)
      req[i] = in_val[i] && (dst[i] == K);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sel        <= SEL_IDLE;
      out_domain <= 1'b0;
      rr         <= 2'd0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      out_domain <= dom_nx;
      rr         <= rr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    rr_nx     = rr;
    dom_nx    = out_domain;
    out_val   = 1'b0;
    grant_rdy = 3'b000;
    cand      = rr;
    found     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Scan rr, rr+1, rr+2; first requester wins.
        for (int j = 0; j < 3; j++) begin
          if (!found && req[cand]) begin
            found    = 1'b1;
            state_nx = ST_LOCKED;
            sel_nx   = cand;
            dom_nx   = in_domain[cand];
          end
          cand = inc3(cand);
        end
      end
      ST_LOCKED: begin
        // Ready does not depend on val: no out_rdy->in_val loop.
        out_val        = req[sel];
        grant_rdy[sel] = out_rdy && (dst[sel] == K);
        if (out_val && out_rdy && in_last[sel]) begin
          state_nx = ST_IDLE;
          sel_nx   = SEL_IDLE;
          rr_nx    = inc3(sel);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/crossbar3_alloc.sv
// 3x3 crossbar allocation and flow control engine.
// Ports: in*_{val,dest,last,domain,rdy}, out*_{rdy,val,domain}, sel*.
module crossbar3_alloc
  import crossbar3_alloc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in0_val,
  input  logic       in1_val,
  input  logic       in2_val,
  input  logic [1:0] in0_dest,
  input  logic [1:0] in1_dest,
  input  logic [1:0] in2_dest,
  input  logic       in0_last,
  input  logic       in1_last,
  input  logic       in2_last,
  input  logic       in0_domain,
  input  logic       in1_domain,
  input  logic       in2_domain,
  output logic       in0_rdy,
  output logic       in1_rdy,
  output logic       in2_rdy,
  input  logic       out0_rdy,
  input  logic       out1_rdy,
  input  logic       out2_rdy,
  output logic       out0_val,
  output logic       out1_val,
  output logic       out2_val,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic       out0_domain,
  output logic       out1_domain,
  output logic       out2_domain
);

  logic [2:0] val, last, dom;
  logic [5:0] dest;
  logic [2:0] g0, g1, g2;

  assign val  = {in2_val, in1_val, in0_val};
  assign dest = {in2_dest, in1_dest, in0_dest};
  assign last = {in2_last, in1_last, in0_last};
  assign dom  = {in2_domain, in1_domain, in0_domain};

  crossbar3_alloc_out #(.K(2'd0)) u_out0 (
    .clk(clk), .reset(reset),
    .in_val(val), .in_dest(dest),
    .in_last(last), .in_domain(dom),
    .out_rdy(out0_rdy), .out_val(out0_val),
    .sel(sel0), .out_domain(out0_domain),
    .grant_rdy(g0)
  );

  crossbar3_alloc_out #(.K(2'd1)) u_out1 (
    .clk(clk), .reset(reset),
    .in_val(val), .in_dest(dest),
    .in_last(last), .in_domain(dom),
    .out_rdy(out1_rdy), .out_val(out1_val),
    .sel(sel1), .out_domain(out1_domain),
    .grant_rdy(g1)
  );

  crossbar3_alloc_out #(.K(2'd2)) u_out2 (
    .clk(clk), .reset(reset),
    .in_val(val), .in_dest(dest),
    .in_last(last), .in_domain(dom),
    .out_rdy(out2_rdy), .out_val(out2_val),
    .sel(sel2), .out_domain(out2_domain),
    .grant_rdy(g2)
  );

  // An input targets one dest at a time, so at most one term is set.
  assign in0_rdy = g0[0] | g1[0] | g2[0];
  assign in1_rdy = g0[1] | g1[1] | g2[1];
  assign in2_rdy = g0[2] | g1[2] | g2[2];

endmodule

// File: tb/tb_crossbar3_alloc.sv
// Randomized bench for crossbar3_alloc against a behavioural model.
// Ports: none; drives and checks the allocator each cycle.
module tb_crossbar3_alloc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v  [3];
  logic [1:0] d  [3];
  logic       l  [3];
  logic       dm [3];
  logic       ordy [3];

  logic       in0_rdy, in1_rdy, in2_rdy;
  logic       out0_val, out1_val, out2_val;
  logic [1:0] sel0, sel1, sel2;
  logic       out0_domain, out1_domain, out2_domain;

  crossbar3_alloc dut (
    .clk(clk), .reset(reset),
    .in0_val(v[0]), .in1_val(v[1]), .in2_val(v[2]),
    .in0_dest(d[0]), .in1_dest(d[1]), .in2_dest(d[2]),
    .in0_last(l[0]), .in1_last(l[1]), .in2_last(l[2]),
    .in0_domain(dm[0]), .in1_domain(dm[1]),
    .in2_domain(dm[2]),
    .in0_rdy(in0_rdy), .in1_rdy(in1_rdy), .in2_rdy(in2_rdy),
    .out0_rdy(ordy[0]), .out1_rdy(ordy[1]),
    .out2_rdy(ordy[2]),
    .out0_val(out0_val), .out1_val(out1_val),
    .out2_val(out2_val),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .out0_domain(out0_domain), .out1_domain(out1_domain),
    .out2_domain(out2_domain)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  // Reference model: per output, who owns it and the rr start.
  bit locked [3];
  int owner  [3];
  bit mdom   [3];
  int ptr    [3];

  logic [1:0] act_sel [3];
  logic       act_val [3];
  logic       act_dom [3];
  logic       act_rdy [3];

  always_comb begin
    act_sel[0] = sel0; act_sel[1] = sel1; act_sel[2] = sel2;
    act_val[0] = out0_val; act_val[1] = out1_val;
    act_val[2] = out2_val;
    act_dom[0] = out0_domain; act_dom[1] = out1_domain;
    act_dom[2] = out2_domain;
    act_rdy[0] = in0_rdy; act_rdy[1] = in1_rdy;
    act_rdy[2] = in2_rdy;
  end

  initial begin
    int mode;
    int tgt;
    for (int k = 0; k < 3; k++) begin
      locked[k] = 0; owner[k] = 0; mdom[k] = 0; ptr[k] = 0;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1; d[i] = 0; l[i] = 0; dm[i] = 0; ordy[i] = 1;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      mode = (cyc / 40) % 4;
      tgt  = (cyc / 160) % 3;
      reset = (cyc < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 3; i++) begin
        if (cyc < 2) begin
          v[i] = 1; d[i] = 0;
        end else begin
          v[i] = ($urandom_range(0, 9) < 8);
          case (mode)
            1: d[i] = 2'(tgt);
            2: d[i] = 2'((i + 2) % 3);
            default: d[i] = 2'($urandom_range(0, 3));
          endcase
        end
        l[i]    = ($urandom_range(0, 2) == 0);
        dm[i]   = 1'($urandom_range(0, 1));
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (cyc > 0) begin
        for (int k = 0; k < 3; k++) begin
          int g;
          g = owner[k];
          check($sformatf("sel%0d", k), 32'(act_sel[k]),
                locked[k] ? 32'(g) : 32'd3);
          check($sformatf("out%0d_val", k), 32'(act_val[k]),
                32'(locked[k] && v[g] && d[g] == k));
          check($sformatf("out%0d_domain", k), 32'(act_dom[k]),
                32'(mdom[k]));
        end
        for (int i = 0; i < 3; i++) begin
          bit r;
          r = 0;
          for (int k = 0; k < 3; k++)
            if (locked[k] && owner[k] == i && d[i] == k && ordy[k])
              r = 1;
          check($sformatf("in%0d_rdy", i), 32'(act_rdy[i]),
                32'(r));
        end
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!reset) begin
          locked[k] = 0; owner[k] = 0; mdom[k] = 0; ptr[k] = 0;
        end else if (locked[k]) begin
          int g;
          g = owner[k];
          if (v[g] && d[g] == k && ordy[k] && l[g]) begin
            locked[k] = 0;
            ptr[k]    = (g + 1) % 3;
          end
        end else begin
          for (int j = 0; j < 3; j++) begin
            int i;
            i = (ptr[k] + j) % 3;
            if (!locked[k] && v[i] && d[i] == k) begin
              locked[k] = 1;
              owner[k]  = i;
              mdom[k]   = dm[i];
            end
          end
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
